// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the iteration and completes in one cycle.
module seq_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE; busy covers the whole operation;
  // done pulses for one cycle with result, which then holds until the next done.

  // fullAdder cell: {carry_out, sum}
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  state_t            state_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   acc_hi_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              rs1_neg;
  logic              rs2_neg;
  logic              zero_skip;
  logic [XLEN-1:0]   rs1_abs;
  logic [XLEN-1:0]   rs2_abs;
  logic [XLEN-1:0]   rs1_twos;
  logic [XLEN-1:0]   rs2_twos;
  logic [XLEN:0]     c1;
  logic [XLEN:0]     c2;
  logic [XLEN-1:0]   step_add;
  logic [XLEN-1:0]   step_sum;
  logic [XLEN:0]     cs;
  logic              step_carry;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_twos;
  logic [2*XLEN-1:0] prod_fix;
  logic [2*XLEN:0]   cn;
  logic [XLEN-1:0]   result_d;
  logic              unused_carries;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH; MUL treats both as unsigned.
  assign rs1_neg = ((op_sel == 2'b01) || (op_sel == 2'b10)) && rs1[XLEN-1];
  assign rs2_neg = (op_sel == 2'b01) && rs2[XLEN-1];

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_skip = (rs1 == '0) || (rs2 == '0);
`else
  assign zero_skip = 1'b0;
`endif

  assign c1[0]    = 1'b1;
  assign c2[0]    = 1'b1;
  assign cs[0]    = 1'b0;
  assign step_add = mplier_q[0] ? mcand_q : '0;

  for (genvar g = 0; g < XLEN; g++) begin : g_xlen_chains
    assign {c1[g+1], rs1_twos[g]} = full_adder(~rs1[g], 1'b0, c1[g]);
    assign {c2[g+1], rs2_twos[g]} = full_adder(~rs2[g], 1'b0, c2[g]);
    assign {cs[g+1], step_sum[g]} = full_adder(acc_hi_q[g], step_add[g], cs[g]);
  end

  assign rs1_abs    = rs1_neg ? rs1_twos : rs1;
  assign rs2_abs    = rs2_neg ? rs2_twos : rs2;
  assign step_carry = cs[XLEN];

  assign prod  = {acc_hi_q, mplier_q};
  assign cn[0] = 1'b1;

  for (genvar g = 0; g < 2*XLEN; g++) begin : g_neg_chain
    assign {cn[g+1], prod_twos[g]} = full_adder(~prod[g], 1'b0, cn[g]);
  end

  assign prod_fix       = neg_q ? prod_twos : prod;
  assign result_d       = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign unused_carries = c1[XLEN] ^ c2[XLEN] ^ cn[2*XLEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op_sel;
            mcand_q  <= rs1_abs;
            mplier_q <= zero_skip ? '0 : rs2_abs;
            acc_hi_q <= '0;
            neg_q    <= (rs1_neg ^ rs2_neg) & ~zero_skip;
            cnt_q    <= CNT_W'(XLEN);
            busy_q   <= 1'b1;
            state_q  <= zero_skip ? S_FIX : S_RUN;
          end
        end
        S_RUN: begin
          // Add-then-shift of {carry, acc_hi, multiplier} in one edge.
          acc_hi_q <= {step_carry, step_sum[XLEN-1:1]};
          mplier_q <= {step_sum[0], mplier_q[XLEN-1:1]};
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
